// File: rtl/ecc_55_wr_enc.sv
// Write-side 55-bit SECDED encoder with a 2-entry registered skid buffer.
// Optional test-only error injector is enabled by defining ECC55_ERR_INJ_EN.
module ecc_55_wr_enc #(
  parameter int DATA_WIDTH   = 55,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [PARITY_WIDTH-1:0] out_parity,
  input  logic                    inj_req,
  input  logic [1:0]              inj_mode,
  input  logic [5:0]              inj_pos,
  output logic                    inj_busy,
  output logic [CNT_WIDTH-1:0]    enc_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // Column i: i-th integer >= 3 that is not a power of two, bit 6 makes weight odd.
  function automatic logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] gen_h();
    logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] h;
    int i;
    h = '0;
    i = 0;
    for (int v = 3; v < 64; v++) begin
      if (((v & (v - 1)) != 0) && (i < DATA_WIDTH)) begin
        h[i][5:0] = v[5:0];
        h[i][6]   = ~^v[5:0];
        i++;
      end
    end
    return h;
  endfunction

  localparam logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] H = gen_h();

  state_t                  state_q, state_d;
  logic                    in_fire, out_fire;
  logic [PARITY_WIDTH-1:0] enc_parity;
  logic [DATA_WIDTH-1:0]   st_data;
  logic [PARITY_WIDTH-1:0] st_parity;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic [PARITY_WIDTH-1:0] skid_parity;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = (state_q != EMPTY);

  always_comb begin
    enc_parity = '0;
    for (int k = 0; k < PARITY_WIDTH; k++)
      for (int i = 0; i < DATA_WIDTH; i++)
        if (H[i][k]) enc_parity[k] = enc_parity[k] ^ in_data[i];
  end

`ifdef ECC55_ERR_INJ_EN
  logic       inj_busy_q;
  logic [1:0] inj_mode_q;
  logic [5:0] inj_pos_q;
  logic [5:0] flip_lo, flip_hi;
  logic [2:0] flip_p;

  assign inj_busy = inj_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_busy_q <= 1'b0;
      inj_mode_q <= 2'b00;
      inj_pos_q  <= '0;
    end else if (inj_busy_q && in_fire) begin
      inj_busy_q <= 1'b0;
    end else if (inj_req && !inj_busy_q && (inj_mode != 2'b00)) begin
      inj_busy_q <= 1'b1;
      inj_mode_q <= inj_mode;
      inj_pos_q  <= inj_pos;
    end
  end

  // Corruption is applied after encoding; out-of-range positions clamp / wrap.
  always_comb begin
    st_data   = in_data;
    st_parity = enc_parity;
    flip_lo   = (inj_pos_q >= 6'd54) ? 6'd54 : inj_pos_q;
    flip_hi   = (inj_pos_q >= 6'd54) ? 6'd0  : inj_pos_q + 6'd1;
    flip_p    = (inj_pos_q[2:0] == 3'd7) ? 3'd6 : inj_pos_q[2:0];
    if (inj_busy_q) begin
      case (inj_mode_q)
        2'b01: st_data[flip_lo] = ~st_data[flip_lo];
        2'b10: begin
          st_data[flip_lo] = ~st_data[flip_lo];
          st_data[flip_hi] = ~st_data[flip_hi];
        end
        2'b11: st_parity[flip_p] = ~st_parity[flip_p];
        default: ;
      endcase
    end
  end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_req, inj_mode, inj_pos};
  assign inj_busy   = 1'b0;
  assign st_data    = in_data;
  assign st_parity  = enc_parity;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_d = TWO;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      TWO: if (out_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Head register drives out_* directly; skid holds the second word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b1;
      out_data    <= '0;
      out_parity  <= '0;
      skid_data   <= '0;
      skid_parity <= '0;
    end else begin
      in_ready <= (state_d != TWO);
      case (state_q)
        EMPTY: if (in_fire) {out_data, out_parity} <= {st_data, st_parity};
        ONE: begin
          if (in_fire && out_fire) {out_data, out_parity}   <= {st_data, st_parity};
          else if (in_fire)        {skid_data, skid_parity} <= {st_data, st_parity};
        end
        TWO: if (out_fire) {out_data, out_parity} <= {skid_data, skid_parity};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           enc_cnt <= '0;
    else if (out_fire && (~&enc_cnt))  enc_cnt <= enc_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ecc_55_wr_enc.sv
// Self-checking bench for ecc_55_wr_enc: directed steps plus random traffic
// against a queue-based reference model of the codeword stream.
module tb_ecc_55_wr_enc;
`ifdef ECC55_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [54:0] in_data, out_data;
  logic [6:0]  out_parity;
  logic        inj_req, inj_busy;
  logic [1:0]  inj_mode;
  logic [5:0]  inj_pos;
  logic [15:0] enc_cnt;

  ecc_55_wr_enc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_parity(out_parity),
    .inj_req(inj_req), .inj_mode(inj_mode), .inj_pos(inj_pos),
    .inj_busy(inj_busy), .enc_cnt(enc_cnt)
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  logic [6:0]  cols [55];
  int          ncol;
  logic [61:0] q [$];
  bit          m_busy;
  logic [1:0]  m_mode;
  logic [5:0]  m_pos;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_par(input logic [54:0] d);
    logic [6:0] p = '0;
    for (int i = 0; i < 55; i++) if (d[i]) p ^= cols[i];
    return p;
  endfunction

  function automatic logic [61:0] ref_cw(input logic [54:0] d, input bit busy,
                                         input logic [1:0] mode, input logic [5:0] pos);
    logic [54:0] x;
    logic [6:0]  p;
    int          b;
    x = d;
    p = ref_par(d);
    if (INJ && busy) begin
      case (mode)
        2'b01: x ^= 55'(1) << ((pos > 54) ? 54 : int'(pos));
        2'b10: x ^= (pos >= 54) ? {1'b1, 53'b0, 1'b1} : (55'(3) << pos);
        2'b11: begin b = int'(pos) % 8; if (b == 7) b = 6; p ^= 7'(1) << b; end
        default: ;
      endcase
    end
    return {x, p};
  endfunction

  task automatic check_state();
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("enc_cnt", 64'(enc_cnt), 64'(m_cnt));
    chk("inj_busy", 64'(inj_busy), 64'(m_busy));
    if (q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(q[0][61:7]));
      chk("out_parity", 64'(out_parity), 64'(q[0][6:0]));
    end
  endtask

  // Advance one clock with the currently driven inputs, updating the model.
  task automatic tick();
    bit          acc, emt;
    logic [61:0] cw;
    acc = in_valid && (q.size() < 2);
    emt = (q.size() > 0) && out_ready;
    cw  = ref_cw(in_data, m_busy, m_mode, m_pos);
    if (emt) begin
      void'(q.pop_front());
      if (m_cnt < 65535) m_cnt++;
    end
    if (acc) q.push_back(cw);
    if (INJ) begin
      if (m_busy && acc) m_busy = 1'b0;
      else if (inj_req && !m_busy && inj_mode != 2'b00) begin
        m_busy = 1'b1; m_mode = inj_mode; m_pos = inj_pos;
      end
    end
    @(posedge clk); #1;
    check_state();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_parity"}, 64'(out_parity), 64'd0);
    chk({tag, "_inj_busy"}, 64'(inj_busy), 64'd0);
    chk({tag, "_enc_cnt"}, 64'(enc_cnt), 64'd0);
  endtask

  // Asserts reset mid-cycle, checks outputs immediately, releases on negedge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset(tag);
    q.delete(); m_busy = 1'b0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [54:0] d);
    in_valid = 1'b1; in_data = d; tick();
  endtask

  initial begin
    ncol = 0;
    for (int v = 3; ncol < 55; v++) begin
      if ($countones(v) != 1) begin
        cols[ncol][5:0] = v[5:0];
        cols[ncol][6]   = ($countones(v) % 2 == 0);
        ncol++;
      end
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    inj_req = 1'b0; inj_mode = 2'b00; inj_pos = '0;
    m_busy = 1'b0; m_mode = 2'b00; m_pos = '0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // Known parity vectors, streaming at full rate
    send(55'h0);
    chk("zero_par", 64'(out_parity), 64'h00);
    send(55'h1);
    chk("d0_par", 64'(out_parity), 64'h43);
    send(55'h1 << 54);
    chk("d54_par", 64'(out_parity), 64'h3D);
    send(55'h9);
    chk("d0d3_par", 64'(out_parity), 64'h44);
    in_valid = 1'b0; tick();

    // Backpressure: fill both entries, stall the third, then drain in order
    do_reset("rst1");
    out_ready = 1'b0;
    send(55'h111); send(55'h222); send(55'h333);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("drain_first", 64'(out_data), 64'h222);
    tick();
    in_valid = 1'b0; tick();
    chk("drain_cnt", 64'(enc_cnt), 64'd3);

    // Injection modes
    inj_req = 1'b1; inj_mode = 2'b01; inj_pos = 6'd5; in_valid = 1'b0; tick();
    inj_req = 1'b0;
    chk("arm_busy", 64'(inj_busy), 64'(INJ));
    send(55'h0);
    chk("inj01_data", 64'(out_data), INJ ? 64'h20 : 64'h0);
    chk("inj01_par", 64'(out_parity), 64'h0);
    send(55'h0);
    chk("after_inj_clean", 64'(out_data), 64'h0);
    inj_req = 1'b1; inj_mode = 2'b10; inj_pos = 6'd54; in_valid = 1'b0; tick();
    inj_req = 1'b0;
    send(55'h0);
    chk("inj10_data", 64'(out_data), INJ ? 64'h40_0000_0000_0001 : 64'h0);
    inj_req = 1'b1; inj_mode = 2'b11; inj_pos = 6'd2; in_valid = 1'b0; tick();
    inj_req = 1'b0;
    send(55'h0);
    chk("inj11_par", 64'(out_parity), INJ ? 64'h04 : 64'h0);
    chk("inj11_data", 64'(out_data), 64'h0);
    in_valid = 1'b0; tick();

    // Random traffic with occasional injection requests
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      inj_req   = ($urandom_range(0, 7) == 0);
      inj_mode  = 2'($urandom_range(0, 3));
      inj_pos   = 6'($urandom_range(0, 63));
      tick();
    end
    inj_req = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();

    // Reset with buffer full and an injection armed
    do_reset("rst2");
    out_ready = 1'b0;
    send(55'h5); send(55'h6);
    in_valid = 1'b0; inj_req = 1'b1; inj_mode = 2'b01; inj_pos = 6'd0; tick();
    inj_req = 1'b0;
    do_reset("rst3");
    out_ready = 1'b1;
    send(55'h1234_5678_9ABC);
    chk("post_rst_par", 64'(out_parity), 64'(ref_par(55'h1234_5678_9ABC)));
    in_valid = 1'b0; tick();
    chk("post_rst_cnt", 64'(enc_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ecc_55_wr_enc.md
Name: ecc_55_wr_enc

Overview:
Write-side SECDED encoder for the 55-bit ECC FIFO path. It accepts 55-bit words over a valid/ready interface and computes the 7-bit check field. It emits the data/parity pair through a registered 2-entry skid buffer, ready to be stored in FIFO RAM. The codeword is bit-exact with the team's 55-bit SECDED read-side checker, and the block carries a test-only error injector so read-path correction can be exercised in-system.

Parameters:
DATA_WIDTH, 55, data bits; fixed, other values unsupported
PARITY_WIDTH, 7, check bits; fixed
CNT_WIDTH, 16, width of the encoded-word counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  upstream word valid
in_ready  out  1  block can accept a word (registered)
in_data  in  55  upstream data
out_valid  out  1  codeword valid
out_ready  in  1  downstream (FIFO write) accepts
out_data  out  55  stored data (possibly corrupted by injection)
out_parity  out  7  stored check bits
inj_req  in  1  one-cycle pulse that arms an injection
inj_mode  in  2  00 none, 01 single data flip, 10 double data flip, 11 single parity flip
inj_pos  in  6  bit position for injection
inj_busy  out  1  injection armed, not yet applied
enc_cnt  out  16  count of output handshakes, saturating

Behaviour:
- Check matrix: the column for d[i] has low 6 bits = the i-th integer ≥3 that is not a power of two, in ascending order (d0=3, d1=5, d2=6, d3=7, d4=9 … d54=61).
- Column bit 6 is set so that column weight is odd (d0=7'b1000011, d3=7'b0000111, d54=7'b0111101).
- p[k] = XOR of all d[i] whose column has bit k set. Parity of all-zero data is 0.
- Handshakes: accept on in_valid&&in_ready; emit on out_valid&&out_ready. Upstream data and mode must stay stable only for the accepting cycle.
- Buffer FSM: EMPTY / ONE / TWO, tracking skid occupancy.
  - EMPTY: accept → ONE.
  - ONE: accept only → TWO; emit only → EMPTY; accept and emit together → ONE (throughput 1 word/cycle).
  - TWO: emit → ONE. No accept is possible in TWO.
  - in_ready = (state != TWO), registered.
- Latency: the word accepted in cycle N is presented on out_* in cycle N+1 at the earliest. Order is strictly preserved.
- out_* hold stable while out_valid && !out_ready.
- Parity is computed from the uncorrupted in_data. Injection is applied after encoding, in the same accept cycle.
- Injection arming:
  - inj_req with inj_busy=0 and inj_mode!=00 sets inj_busy and latches mode/pos.
  - inj_req while busy is ignored; mode 00 is ignored.
  - Arming takes effect from the next cycle, so a word accepted in the arming cycle is not corrupted.
- Injection application: the next accepted word is corrupted, then inj_busy clears in that cycle.
  - 01: flip data[pos]; pos > 54 flips bit 54.
  - 10: flip data[pos] and data[pos+1]; pos ≥ 54 flips bits 54 and 0.
  - 11: flip parity[pos[2:0]]; pos[2:0]=7 flips bit 6.
- enc_cnt increments on each emit handshake and saturates at all-ones.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_parity=0, inj_busy=0, enc_cnt=0, state EMPTY.
- Reset mid-operation drops buffered words and any armed injection immediately. The first accept after reset release is legal in the first clock.

Optional Feature:
ECC55_ERR_INJ_EN
- Defined: injection logic as above.
- Undefined: inj_req, inj_mode and inj_pos are ignored, inj_busy is tied 0, and out_data/out_parity are always the clean codeword. Ports remain, so the interface is unchanged.

Test Plan:
- Reset, then in_data=0 → next cycle out_valid=1, out_data=0, out_parity=7'h00; in_ready stays 1.
- in_data=55'h1 → out_parity=7'h43. in_data=bit54 only → 7'h3D. in_data=bits0|3 → 7'h44.
- Hold out_ready=0 and offer 3 words → after 2 accepts in_ready=0 and the third is stalled. Release out_ready → words emitted in order, one per cycle, and enc_cnt=3.
- Macro defined, inj_req with mode=01, pos=5, then send data=0 → out_data=55'h20, out_parity=0, inj_busy falls on the accept. The following word is clean.
- Mode=10, pos=54 on data=0 → out_data bits 54 and 0 set. Mode=11, pos=2 → out_parity=7'h04, data clean.
- Assert rst with the buffer in TWO and an injection armed → outputs return to reset values the same cycle. After release, a clean word encodes correctly and enc_cnt=1 after its emit.
